ext_itf_ctrl: RTL and testbench

Chip-side controller for the shared off-chip data port. It accepts one transfer request at a time from the on-chip scheduler: direction, DRAM word address and beat count. It announces the request with a command pulse, sends the command word, then streams read beats into the chip or write beats out to DRAM. Pad tri-state muxing is outside this block; all port signals are split into in/out pairs with a single output-enable.

---
 rtl/ext_itf_ctrl_if.sv | 47 ++++
 rtl/ext_itf_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ext_itf_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_itf_ctrl_if.sv
// ext_itf_ctrl_if: bundle of every handshake and bus signal around the off-chip port controller.
//   Scheduler side : req_vld/req_rdy/req_wr/req_addr/req_len, done
//   Write client   : wdat/wdat_vld/wdat_rdy
//   Read client    : rdat/rdat_vld/rdat_rdy
//   Pad side       : pad_cmd_vld, pad_oe, pad_dat_o/pad_vld_o/pad_rdy_i,
//                    pad_dat_i/pad_vld_i/pad_rdy_o (tri-state muxing lives outside)
// Modports: master = the controller, slave = scheduler/clients/pads around it.
interface ext_itf_ctrl_if #(
  parameter int unsigned PORT_WIDTH      = 128,
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH       = 16
);
  logic                       req_vld;
  logic                       req_rdy;
  logic                       req_wr;
  logic [DRAM_ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]       req_len;
  logic                       done;
  logic [PORT_WIDTH-1:0]      wdat;
  logic                       wdat_vld;
  logic                       wdat_rdy;
  logic [PORT_WIDTH-1:0]      rdat;
  logic                       rdat_vld;
  logic                       rdat_rdy;
  logic                       pad_cmd_vld;
  logic                       pad_oe;
  logic [PORT_WIDTH-1:0]      pad_dat_o;
  logic                       pad_vld_o;
  logic                       pad_rdy_i;
  logic [PORT_WIDTH-1:0]      pad_dat_i;
  logic                       pad_vld_i;
  logic                       pad_rdy_o;

  modport master (
    input  req_vld, req_wr, req_addr, req_len, wdat, wdat_vld, rdat_rdy,
    input  pad_rdy_i, pad_dat_i, pad_vld_i,
    output req_rdy, done, wdat_rdy, rdat, rdat_vld,
    output pad_cmd_vld, pad_oe, pad_dat_o, pad_vld_o, pad_rdy_o
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_len, wdat, wdat_vld, rdat_rdy,
    output pad_rdy_i, pad_dat_i, pad_vld_i,
    input  req_rdy, done, wdat_rdy, rdat, rdat_vld,
    input  pad_cmd_vld, pad_oe, pad_dat_o, pad_vld_o, pad_rdy_o
  );
endinterface

// File: rtl/ext_itf_ctrl.sv
// ext_itf_ctrl: chip-side controller for the shared off-chip data port.
// Accepts one transfer at a time, pulses pad_cmd_vld, sends the command word
// {upper 0, addr, wr}, then streams write beats out or read beats in.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - ext_itf_ctrl_if.master (scheduler, read/write clients, pad in/out pairs)
// Build option: define ITF_RDBUF_EN for a 2-entry registered read FIFO between
// pad_dat_i and rdat; otherwise reads pass straight through with zero latency.
// DRAM_ADDR_WIDTH + 1 must not exceed PORT_WIDTH so the command word fits.
module ext_itf_ctrl #(
  parameter int unsigned PORT_WIDTH      = 128,
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input logic            clk,
  input logic            rst_n,
  ext_itf_ctrl_if.master bus
);

  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StAnn, StCmd, StRd, StWr, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       wr_q, wr_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       req_rdy_q, pad_cmd_vld_q, pad_oe_q, done_q;

  logic                       last_beat;
  logic                       wr_hs;
  logic                       rd_hs;
  logic                       rd_exit;
  logic                       pad_rdy_o_w;
  logic [PORT_WIDTH-1:0]      cmd_word;

  assign last_beat = (cnt_q == (len_q - LenOne));
  assign wr_hs     = (state_q == StWr) && bus.wdat_vld && bus.pad_rdy_i;
  assign rd_hs     = bus.pad_vld_i && pad_rdy_o_w;

`ifdef ITF_RDBUF_EN
  logic [PORT_WIDTH-1:0] fifo_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            fcnt_q;
  logic                  push, pop, rx_all;

  // cnt reaches len only here: the last beat is in, but RD must wait for the drain.
  assign rx_all      = (cnt_q == len_q);
  assign pad_rdy_o_w = (state_q == StRd) && (fcnt_q != 2'd2) && !rx_all;
  assign push        = rd_hs;
  assign pop         = (fcnt_q != 2'd0) && bus.rdat_rdy;
  assign bus.rdat     = fifo_q[rptr_q];
  assign bus.rdat_vld = (fcnt_q != 2'd0);
  // Leave RD in the cycle that pops the final entry, so DONE sees an empty FIFO.
  assign rd_exit     = rx_all && ((fcnt_q == 2'd0) || ((fcnt_q == 2'd1) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      fcnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= bus.pad_dat_i;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
    end
  end
`else
  assign pad_rdy_o_w  = bus.rdat_rdy && (state_q == StRd);
  assign bus.rdat     = bus.pad_dat_i;
  assign bus.rdat_vld = bus.pad_vld_i && (state_q == StRd);
  assign rd_exit      = rd_hs && last_beat;
`endif

  always_comb begin
    cmd_word                      = '0;
    cmd_word[0]                   = wr_q;
    cmd_word[DRAM_ADDR_WIDTH:1]   = addr_q;
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_vld) begin
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          cnt_d   = '0;
          state_d = (bus.req_len == '0) ? StDone : StAnn;
        end
      end
      StAnn: state_d = StCmd;
      StCmd: begin
        if (bus.pad_rdy_i) begin
          state_d = wr_q ? StWr : StRd;
        end
      end
      StWr: begin
        if (wr_hs) begin
          cnt_d = cnt_q + LenOne;
          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StRd: begin
        if (rd_hs) begin
          cnt_d = cnt_q + LenOne;
        end
        if (rd_exit) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, transfer registers and state-decoded outputs, all updated from state_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      req_rdy_q     <= 1'b1;
      pad_cmd_vld_q <= 1'b0;
      pad_oe_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      req_rdy_q     <= (state_d == StIdle);
      pad_cmd_vld_q <= (state_d == StAnn);
      pad_oe_q      <= (state_d == StCmd) || (state_d == StWr);
      done_q        <= (state_d == StDone);
    end
  end

  assign bus.req_rdy     = req_rdy_q;
  assign bus.done        = done_q;
  assign bus.pad_cmd_vld = pad_cmd_vld_q;
  assign bus.pad_oe      = pad_oe_q;
  assign bus.pad_rdy_o   = pad_rdy_o_w;
  assign bus.wdat_rdy    = (state_q == StWr) && bus.pad_rdy_i;
  assign bus.pad_vld_o   = (state_q == StCmd) || ((state_q == StWr) && bus.wdat_vld);
  assign bus.pad_dat_o   = (state_q == StCmd) ? cmd_word :
                           (state_q == StWr)  ? bus.wdat : '0;

endmodule

// File: tb/tb_ext_itf_ctrl.sv
// tb_ext_itf_ctrl: self-checking bench for ext_itf_ctrl with a behavioural DRAM on the
// pad side, read/write clients, a table of transfers and hand-written corner sequences.
module tb_ext_itf_ctrl;
  localparam int unsigned PW = 128;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
`ifdef ITF_RDBUF_EN
  localparam int BpLimit = 2;
`else
  localparam int BpLimit = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ext_itf_ctrl_if #(.PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ext_itf_ctrl #(.PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [15:0] len;
    bit          slow;
    logic [127:0] cmd;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] mem [1024];
  logic [127:0] rd_q[$];
  logic [127:0] wr_exp[$];
  logic [127:0] wbeats[$];
  logic [127:0] wsave[$];
  logic [127:0] exp_cmd_q[$];

  // model / monitor observations
  int phase = 0, idx = 0, ann_cyc = 0, cmdw_cyc = -1, last_wr_cyc = 0, n_ann = 0;
  bit dram_wr = 1'b0;
  logic [31:0] dram_addr = '0;
  bit dram_slow = 1'b0;
  int done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, rd_pops = 0, viol = 0, hold_acc = 0;
  int oe_cycles = 0, hold_cnt = 0, acc_cyc = 0;

  function automatic void check(input string nm, input logic [127:0] act,
                                input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endfunction

  function automatic void fail(input string nm, input string act, input string req);
    n_chk++;
    $display("FAIL %s: actual %s required %s", nm, act, req);
  endfunction

  // DRAM model: decodes the command word, serves reads, stores and scores writes.
  initial begin
    logic [127:0] w;
    logic [9:0] mi;
    bus.pad_rdy_i = 1'b1;
    bus.pad_vld_i = 1'b1;
    bus.pad_dat_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
      end else if (bus.pad_cmd_vld) begin
        check("ann_oe_low", 128'(bus.pad_oe), 128'(0));
        phase = 1; ann_cyc = cyc; n_ann++; cmdw_cyc = -1;
      end else if (phase == 1 && bus.pad_oe && bus.pad_vld_o) begin
        if (cmdw_cyc < 0) cmdw_cyc = cyc;
        if (bus.pad_rdy_i) begin
          w = bus.pad_dat_o;
          if (exp_cmd_q.size() == 0) fail("cmd_unexpected", $sformatf("%0h", w), "none");
          else check("cmd_word", w, exp_cmd_q.pop_front());
          dram_wr = w[0]; dram_addr = w[AW:1]; idx = 0; phase = 2;
        end
      end else if (phase == 2) begin
        if (dram_wr && bus.pad_oe && bus.pad_vld_o && bus.pad_rdy_i) begin
          mi = 10'(dram_addr + 32'(idx));
          mem[mi] = bus.pad_dat_o;
          if (wr_exp.size() == 0) fail("wr_extra", $sformatf("%0h", bus.pad_dat_o), "none");
          else check("wr_beat", bus.pad_dat_o, wr_exp.pop_front());
          idx++; last_wr_cyc = cyc;
        end
        if (!dram_wr && bus.pad_vld_i && bus.pad_rdy_o) idx++;
      end
      @(posedge clk); #1;
      bus.pad_rdy_i = dram_slow ? (cyc % 3 != 0) : 1'b1;
      mi = 10'(dram_addr + 32'(idx));
      bus.pad_dat_i = mem[mi];
    end
  end

  // Read/write clients.
  initial begin
    bit wtog;
    wtog = 1'b0;
    bus.rdat_rdy = 1'b1;
    bus.wdat_vld = 1'b0;
    bus.wdat = '0;
    forever begin
      @(posedge clk); #1;
      bus.rdat_rdy = (hold_cnt == 0);
      if (hold_cnt > 0) hold_cnt--;
      if (wbeats.size() > 0) begin
        wtog = !wtog; bus.wdat_vld = wtog; bus.wdat = wbeats[0];
      end else begin
        bus.wdat_vld = 1'b0;
      end
    end
  end

  // Monitor: read scoreboard, done pulses and pad-side invariants.
  initial begin
    logic [127:0] tmp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.rdat_vld && bus.rdat_rdy) begin
          if (rd_q.size() == 0) fail("rd_extra", $sformatf("%0h", bus.rdat), "none");
          else check("rd_beat", bus.rdat, rd_q.pop_front());
          rd_pops++; last_pop_cyc = cyc;
        end
        if (!bus.rdat_rdy && bus.pad_vld_i && bus.pad_rdy_o) hold_acc++;
        if (bus.pad_oe && bus.pad_cmd_vld) viol++;
        if (!bus.pad_oe && (bus.pad_vld_o || bus.pad_dat_o != '0 || bus.wdat_rdy)) viol++;
        if (bus.pad_oe) oe_cycles++;
        if (bus.wdat_vld && bus.wdat_rdy) tmp = wbeats.pop_front();
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [15:0] len,
                       input logic [127:0] cmd);
    logic [127:0] v;
    bit got;
    for (int i = 0; i < int'(len); i++) begin
      if (wr) begin
        v = {$urandom, $urandom, $urandom, $urandom};
        wbeats.push_back(v); wr_exp.push_back(v); wsave.push_back(v);
      end else begin
        rd_q.push_back(mem[10'(addr + 32'(i))]);
      end
    end
    if (len != 0) exp_cmd_q.push_back(cmd);
    @(posedge clk); #1;
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_len = len;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.req_rdy) got = 1'b1;
    end
    if (!got) fail("accept_timeout", "no req_rdy", "accept");
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 2000 && done_cnt < target; n++) @(posedge clk);
    if (done_cnt < target) fail("done_timeout", $sformatf("%0d", done_cnt), $sformatf("%0d", target));
  endtask

  task automatic wait_pops(input int target);
    for (int n = 0; n < 500 && rd_pops < target; n++) @(posedge clk);
    if (rd_pops < target) fail("pop_timeout", $sformatf("%0d", rd_pops), $sformatf("%0d", target));
  endtask

  task automatic run_xfer(input string nm, input bit wr, input logic [31:0] addr,
                          input logic [15:0] len, input logic [127:0] cmd, input bit slow);
    int ann0, oe0;
    dram_slow = slow; done_cnt = 0; rd_pops = 0; wsave.delete();
    ann0 = n_ann; oe0 = oe_cycles;
    issue(wr, addr, len, cmd);
    wait_done(1);
    repeat (2) @(posedge clk);
    check({nm, "_done_once"}, 128'(done_cnt), 128'(1));
    if (len == 0) begin
      check({nm, "_no_ann"}, 128'(n_ann), 128'(ann0));
      check({nm, "_no_oe"}, 128'(oe_cycles), 128'(oe0));
      check({nm, "_done_cyc"}, 128'(done_cyc), 128'(acc_cyc + 1));
    end else begin
      check({nm, "_ann_cyc"}, 128'(ann_cyc), 128'(acc_cyc + 1));
      check({nm, "_cmdw_cyc"}, 128'(cmdw_cyc), 128'(acc_cyc + 2));
      check({nm, "_done_cyc"}, 128'(done_cyc), 128'((wr ? last_wr_cyc : last_pop_cyc) + 1));
    end
    check({nm, "_queues_empty"}, 128'(rd_q.size() + wr_exp.size() + exp_cmd_q.size()), 128'(0));
    if (wr) begin
      for (int i = 0; i < int'(len); i++)
        check($sformatf("%s_mem%0d", nm, i), mem[10'(addr + 32'(i))], wsave[i]);
    end else begin
      check({nm, "_rd_count"}, 128'(rd_pops), 128'(len));
    end
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b0, 32'h100, 16'd4, 1'b0, 128'h200};
    vecs[1] = '{1'b1, 32'h40, 16'd3, 1'b0, 128'h81};
    vecs[2] = '{1'b0, 32'h3, 16'd1, 1'b0, 128'h6};
    vecs[3] = '{1'b1, 32'h1FF, 16'd5, 1'b1, 128'h3FF};
    vecs[4] = '{1'b0, 32'h80, 16'd6, 1'b1, 128'h100};
    vecs[5] = '{1'b1, 32'hFFFF_FFF0, 16'd2, 1'b0, 128'h1_FFFF_FFE1};

    for (int i = 0; i < 1024; i++)
      mem[i] = {32'(i) * 32'd3 + 32'd7, 32'hA5A5_0000 + 32'(i), ~32'(i), 32'(i)};
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_len = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_rdy", 128'(bus.req_rdy), 128'(1));
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_cmd_vld", 128'(bus.pad_cmd_vld), 128'(0));
    check("rst_oe", 128'(bus.pad_oe), 128'(0));
    check("rst_pad_vld_o", 128'(bus.pad_vld_o), 128'(0));
    check("rst_pad_rdy_o", 128'(bus.pad_rdy_o), 128'(0));
    check("rst_rdat_vld", 128'(bus.rdat_vld), 128'(0));
    check("rst_wdat_rdy", 128'(bus.wdat_rdy), 128'(0));

    for (int i = 0; i < 6; i++)
      run_xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].cmd,
               vecs[i].slow);

    run_xfer("zero_len", 1'b0, 32'h300, 16'd0, 128'h0, 1'b0);

    // Read with client backpressure mid-transfer.
    dram_slow = 1'b0; done_cnt = 0; rd_pops = 0;
    issue(1'b0, 32'h180, 16'd8, 128'h300);
    wait_pops(2);
    hold_acc = 0; hold_cnt = 5;
    wait_done(1);
    repeat (2) @(posedge clk);
    check("bp_pad_accepts_within_limit", 128'(hold_acc <= BpLimit), 128'(1));
    check("bp_rd_count", 128'(rd_pops), 128'(8));
    check("bp_rd_q_empty", 128'(rd_q.size()), 128'(0));
    check("bp_done_once", 128'(done_cnt), 128'(1));

    // Reset after the second beat of an 8-beat read.
    done_cnt = 0; rd_pops = 0;
    issue(1'b0, 32'h200, 16'd8, 128'h400);
    wait_pops(2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_rdy", 128'(bus.req_rdy), 128'(1));
    check("mid_rst_done", 128'(bus.done), 128'(0));
    check("mid_rst_oe", 128'(bus.pad_oe), 128'(0));
    check("mid_rst_pad_rdy_o", 128'(bus.pad_rdy_o), 128'(0));
    check("mid_rst_rdat_vld", 128'(bus.rdat_vld), 128'(0));
    check("mid_rst_pad_dat_o", bus.pad_dat_o, 128'(0));
`ifdef ITF_RDBUF_EN
    check("mid_rst_rdat", bus.rdat, 128'(0));
`endif
    rd_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("mid_rst_no_done", 128'(done_cnt), 128'(0));
    check("mid_rst_pops", 128'(rd_pops), 128'(2));
    run_xfer("after_rst", 1'b0, 32'h205, 16'd1, 128'h40A, 1'b0);

    // Back-to-back: read len 2, then write len 2 queued behind it.
    done_cnt = 0; rd_pops = 0; wsave.delete();
    issue(1'b0, 32'h10, 16'd2, 128'h20);
    issue(1'b1, 32'h20, 16'd2, 128'h41);
    wait_done(2);
    repeat (2) @(posedge clk);
    check("b2b_done_twice", 128'(done_cnt), 128'(2));
    check("b2b_ann_gap", 128'(ann_cyc), 128'(last_pop_cyc + 3));
    check("b2b_queues_empty", 128'(rd_q.size() + wr_exp.size() + exp_cmd_q.size()), 128'(0));
    for (int i = 0; i < 2; i++)
      check($sformatf("b2b_mem%0d", i), mem[10'(32'h20 + 32'(i))], wsave[i]);

    check("pad_invariants", 128'(viol), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
